// File: rtl/repeat_range_pkg.sv
// Shared types and helpers for the repeat_range generator.
package repeat_range_pkg;

  typedef enum logic [1:0] {
    LAUNCH,
    FETCH,
    EMIT,
    DONE
  } state_t;

  // Number of bits needed to hold any count 0..max_repeat.
  function automatic int repeat_width(input int max_repeat);
    return $clog2(max_repeat + 1);
  endfunction

  // Saturate a requested repeat count at the largest supported value.
  function automatic int unsigned clamp_repeat(input int unsigned requested,
                                               input int unsigned max_repeat);
    return (requested > max_repeat) ? max_repeat : requested;
  endfunction

endpackage

// File: rtl/repeat_range_hrange.sv
// hrange: emits base, base+step, ... while the value stays below limit.
// The current value is presented with _valid and advances on _valid && _ready.
module hrange #(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0
);

  logic signed [WIDTH-1:0] cur_r;
  logic signed [WIDTH-1:0] limit_r;
  logic signed [WIDTH-1:0] step_r;
  logic                    run_r;
  logic                    done_r;
  logic signed [WIDTH:0]   next_wide;
  logic signed [WIDTH:0]   limit_wide;

  // One extra bit keeps the end-of-range test correct when cur+step overflows.
  assign next_wide  = {cur_r[WIDTH-1], cur_r} + {step_r[WIDTH-1], step_r};
  assign limit_wide = {limit_r[WIDTH-1], limit_r};

  assign _valid = run_r;
  assign _done  = done_r;
  assign _0     = cur_r;

  // Capture a new range on start, then step through it one accepted value at a time.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      cur_r   <= '0;
      limit_r <= '0;
      step_r  <= '0;
      run_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (_start) begin
      cur_r   <= base;
      limit_r <= limit;
      step_r  <= step;
      if ((step > $signed({WIDTH{1'b0}})) && (base < limit)) begin
        run_r  <= 1'b1;
        done_r <= 1'b0;
      end else begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end
    end else if (run_r && _ready) begin
      cur_r <= cur_r + step_r;
      if (next_wide >= limit_wide) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/repeat_range.sv
// repeat_range: replays every value of an hrange child `repeat_count` times,
// tagging each beat with its copy index, towards a ready/valid consumer.
module repeat_range
  import repeat_range_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int MAX_REPEAT = 4,
  localparam int RW         = repeat_width(MAX_REPEAT)
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic [RW-1:0]           repeat_count,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic [RW-1:0]           _1
);

  localparam logic signed [WIDTH-1:0] ZERO = '0;

  state_t state;
  state_t state_next;

  logic signed [WIDTH-1:0] base_r;
  logic signed [WIDTH-1:0] limit_r;
  logic signed [WIDTH-1:0] step_r;
  logic signed [WIDTH-1:0] value_r;
  logic [RW-1:0]           rep_r;
  logic [RW-1:0]           copy_r;
  logic [RW-1:0]           rep_clamped;

  // Child interface: registered controls, wired results.
  logic                    child_start_r;
  logic                    child_ready_r;
  logic                    child_ready;
  logic                    child_valid;
  logic                    child_done;
  logic signed [WIDTH-1:0] child_value;

  logic advance;
  logic degenerate;
  logic last_copy;
  logic child_take;
  logic child_finished;
  logic launch_child;
  logic latch_value;
  logic fetch_stop;
  logic emit_beat;

  assign rep_clamped = RW'(clamp_repeat(32'(repeat_count), 32'(MAX_REPEAT)));

  assign advance    = _ready || !_valid;
  assign degenerate = (step_r <= ZERO) || (rep_r == '0) || (base_r >= limit_r);
  assign last_copy  = (copy_r == rep_r - RW'(1));

  // The child is only allowed to hand over a value when we can move as well,
  // so a stalled consumer never makes us lose a child value.
  assign child_ready = child_ready_r && advance;
  assign child_take  = child_valid && child_ready;

  // While a start is still in flight to the child its done flag belongs to the
  // previous run and must be ignored.
  assign child_finished = child_done && !child_start_r;

  // State register: a new start wins over reset, otherwise follow the FSM.
  always_ff @(posedge _clock) begin
    if (_start) begin
      state <= LAUNCH;
    end else if (_reset) begin
      state <= DONE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every transition requires the output slot to be free.
  always_comb begin
    state_next = state;
    case (state)
      LAUNCH: if (advance) state_next = degenerate ? DONE : FETCH;
      FETCH: begin
        if (latch_value) begin
          state_next = EMIT;
        end else if (fetch_stop) begin
          state_next = DONE;
        end
      end
      EMIT:    if (emit_beat && last_copy) state_next = FETCH;
      DONE:    state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  // Per-state action strobes; a child value takes priority over child done.
  always_comb begin
    launch_child = 1'b0;
    latch_value  = 1'b0;
    fetch_stop   = 1'b0;
    emit_beat    = 1'b0;
    if (advance) begin
      case (state)
        LAUNCH: launch_child = !degenerate;
        FETCH: begin
          latch_value = child_take;
          fetch_stop  = !child_take && child_finished;
        end
        EMIT:    emit_beat = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: capture arguments, drive the child, and present output beats.
  always_ff @(posedge _clock) begin
    if (_start) begin
      base_r        <= base;
      limit_r       <= limit;
      step_r        <= step;
      rep_r         <= rep_clamped;
      _valid        <= 1'b0;
      _done         <= 1'b0;
      child_start_r <= 1'b0;
      child_ready_r <= 1'b0;
    end else if (_reset) begin
      _valid        <= 1'b0;
      _0            <= '0;
      _1            <= '0;
      _done         <= 1'b0;
      child_start_r <= 1'b0;
      child_ready_r <= 1'b0;
    end else begin
      _done         <= (state == DONE);
      child_start_r <= launch_child;
      if (_ready) begin
        _valid <= 1'b0;
      end
      if ((state == FETCH) && advance) begin
        child_ready_r <= !(latch_value || fetch_stop);
      end
      if (launch_child) begin
        child_ready_r <= 1'b0;
      end
      if (latch_value) begin
        value_r <= child_value;
        copy_r  <= '0;
      end
      if (emit_beat) begin
        _0     <= value_r;
        _1     <= copy_r;
        _valid <= 1'b1;
        if (!last_copy) begin
          copy_r <= copy_r + RW'(1);
        end
      end
    end
  end

  hrange #(
    .WIDTH(WIDTH)
  ) u_hrange (
    ._clock(_clock),
    ._reset(_reset),
    ._start(child_start_r),
    .base  (base_r),
    .limit (limit_r),
    .step  (step_r),
    ._ready(child_ready),
    ._valid(child_valid),
    ._done (child_done),
    ._0    (child_value)
  );

endmodule

// File: tb/tb_repeat_range.sv
// Directed testbench for repeat_range with hand-computed expected beat lists.
module tb_repeat_range;

  localparam int WIDTH      = 32;
  localparam int MAX_REPEAT = 4;
  localparam int RW         = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    ready;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic [RW-1:0]           rep;
  logic                    valid;
  logic                    done;
  logic signed [WIDTH-1:0] o0;
  logic [RW-1:0]           o1;

  int checks   = 0;
  int failures = 0;

  logic signed [WIDTH-1:0] got_v[$];
  logic [RW-1:0]           got_c[$];
  int                      hold_bad;
  bit                      saw_done;

  repeat_range #(
    .WIDTH     (WIDTH),
    .MAX_REPEAT(MAX_REPEAT)
  ) dut (
    ._clock      (clk),
    ._reset      (rst),
    ._start      (start),
    .base        (base),
    .limit       (limit),
    .step        (step),
    .repeat_count(rep),
    ._ready      (ready),
    ._valid      (valid),
    ._done       (done),
    ._0          (o0),
    ._1          (o1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_gen(input int b, input int l, input int s, input logic [RW-1:0] r);
    base  = b;
    limit = l;
    step  = s;
    rep   = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Gathers accepted beats until done or the cycle budget runs out.
  task automatic collect(input int max_cycles, input bit toggle);
    bit                      prev_hold;
    logic signed [WIDTH-1:0] p0;
    logic [RW-1:0]           p1;
    prev_hold = 1'b0;
    p0        = '0;
    p1        = '0;
    got_v.delete();
    got_c.delete();
    hold_bad = 0;
    saw_done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      ready = toggle ? ((i % 2) == 0) : 1'b1;
      if (prev_hold && ((valid !== 1'b1) || (o0 !== p0) || (o1 !== p1))) hold_bad++;
      prev_hold = valid && !ready;
      p0        = o0;
      p1        = o1;
      if (valid && ready) begin
        got_v.push_back(o0);
        got_c.push_back(o1);
      end
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      tick();
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %0b expected 0", valid);
    end
    checks++;
    if (o0 !== 0) begin
      failures++;
      $display("[TB] FAIL reset_o0: got %0d expected 0", o0);
    end
    checks++;
    if (o1 !== 0) begin
      failures++;
      $display("[TB] FAIL reset_o1: got %0d expected 0", o1);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_done: got %0b expected 1", done);
    end
  endtask

  task automatic test_basic();
    int exp_v[10] = '{0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
    int n;
    int extra;
    start_gen(0, 10, 2, 3'd2);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done_cleared: got %0b expected 0", done);
    end
    collect(200, 1'b0);
    checks++;
    if (got_v.size() !== 10) begin
      failures++;
      $display("[TB] FAIL basic_len: got %0d expected 10", got_v.size());
    end
    n = (got_v.size() < 10) ? got_v.size() : 10;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_v[i] !== exp_v[i]) begin
        failures++;
        $display("[TB] FAIL basic_value[%0d]: got %0d expected %0d", i, got_v[i], exp_v[i]);
      end
      checks++;
      if (got_c[i] !== RW'(i % 2)) begin
        failures++;
        $display("[TB] FAIL basic_copy[%0d]: got %0d expected %0d", i, got_c[i], i % 2);
      end
    end
    checks++;
    if (!saw_done) begin
      failures++;
      $display("[TB] FAIL basic_done: got timeout expected done");
    end
    extra = 0;
    repeat (6) begin
      if (valid) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("[TB] FAIL basic_after_done: got %0d valid cycles expected 0", extra);
    end
  endtask

  task automatic test_ready_toggle();
    int n;
    start_gen(-3, 0, 1, 3'd3);
    collect(300, 1'b1);
    checks++;
    if (got_v.size() !== 9) begin
      failures++;
      $display("[TB] FAIL toggle_len: got %0d expected 9", got_v.size());
    end
    n = (got_v.size() < 9) ? got_v.size() : 9;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_v[i] !== (-3 + i / 3)) begin
        failures++;
        $display("[TB] FAIL toggle_value[%0d]: got %0d expected %0d", i, got_v[i], -3 + i / 3);
      end
      checks++;
      if (got_c[i] !== RW'(i % 3)) begin
        failures++;
        $display("[TB] FAIL toggle_copy[%0d]: got %0d expected %0d", i, got_c[i], i % 3);
      end
    end
    checks++;
    if (hold_bad !== 0) begin
      failures++;
      $display("[TB] FAIL toggle_hold: got %0d unstable stalled cycles expected 0", hold_bad);
    end
    checks++;
    if (!saw_done) begin
      failures++;
      $display("[TB] FAIL toggle_done: got timeout expected done");
    end
  endtask

  task automatic test_degenerate();
    int          steps[3] = '{1, 0, -1};
    logic [RW-1:0] reps[3] = '{3'd0, 3'd2, 3'd2};
    int          seen;
    for (int k = 0; k < 3; k++) begin
      start_gen(0, 5, steps[k], reps[k]);
      seen = valid ? 1 : 0;
      tick();
      if (valid) seen++;
      tick();
      if (valid) seen++;
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL degenerate_done[%0d]: got %0b expected 1", k, done);
      end
      checks++;
      if (seen !== 0) begin
        failures++;
        $display("[TB] FAIL degenerate_valid[%0d]: got %0d valid cycles expected 0", k, seen);
      end
    end
  endtask

  task automatic test_clamp();
    int n;
    start_gen(0, 2, 1, 3'd7);
    collect(200, 1'b0);
    checks++;
    if (got_v.size() !== 8) begin
      failures++;
      $display("[TB] FAIL clamp_len: got %0d expected 8", got_v.size());
    end
    n = (got_v.size() < 8) ? got_v.size() : 8;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ((got_v[i] !== (i / 4)) || (got_c[i] !== RW'(i % 4))) begin
        failures++;
        $display("[TB] FAIL clamp_beat[%0d]: got %0d/%0d expected %0d/%0d",
                 i, got_v[i], got_c[i], i / 4, i % 4);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int beats;
    int stale;
    bit hit;
    start_gen(0, 10, 1, 3'd2);
    beats = 0;
    hit   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (valid && ready) beats++;
      if (beats == 3) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL midreset_reach: got %0d beats expected 3", beats);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_valid: got %0b expected 0", valid);
    end
    stale = 0;
    repeat (20) begin
      if (valid) stale++;
      tick();
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("[TB] FAIL midreset_stale: got %0d valid cycles expected 0", stale);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_done: got %0b expected 1", done);
    end
  endtask

  task automatic test_start_over_reset();
    int beats;
    start_gen(0, 10, 1, 3'd2);
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid && ready) beats++;
      if (beats == 2) break;
      tick();
    end
    base  = 100;
    limit = 102;
    step  = 1;
    rep   = 3'd1;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    collect(200, 1'b0);
    checks++;
    if (got_v.size() !== 2) begin
      failures++;
      $display("[TB] FAIL restart_len: got %0d expected 2", got_v.size());
    end
    if (got_v.size() >= 2) begin
      checks++;
      if ((got_v[0] !== 100) || (got_c[0] !== 0)) begin
        failures++;
        $display("[TB] FAIL restart_beat0: got %0d/%0d expected 100/0", got_v[0], got_c[0]);
      end
      checks++;
      if ((got_v[1] !== 101) || (got_c[1] !== 0)) begin
        failures++;
        $display("[TB] FAIL restart_beat1: got %0d/%0d expected 101/0", got_v[1], got_c[1]);
      end
    end
    checks++;
    if (!saw_done) begin
      failures++;
      $display("[TB] FAIL restart_done: got timeout expected done");
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    base  = '0;
    limit = '0;
    step  = '0;
    rep   = '0;
    tick();
    test_reset();
    test_basic();
    test_ready_toggle();
    test_degenerate();
    test_clamp();
    test_reset_midstream();
    test_start_over_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
